wb_scoreboard: RTL

- Producer-side companion to the operand forwarding path. Tracks every in-flight register write from issue to writeback, including multi-cycle long ops (MUL/DIV).
- Tells the ID stage when an operand can be forwarded and when issue must stall.
- Sits between ID-stage issue logic and the WB/long-op completion ports.
- The forwarding mux trusts its matches only while this block deasserts stall.

---
 rtl/wb_scoreboard_if.sv | 34 +++
 rtl/wb_scoreboard.sv | 137 +++++++++++++
 2 files changed

// File: rtl/wb_scoreboard_if.sv
// Issue / writeback / long-completion bundle between the ID stage and wb_scoreboard.
interface wb_scoreboard_if;
    logic       issue_valid;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic       issue_use_rs1;
    logic       issue_use_rs2;
    logic       issue_we;
    logic [4:0] issue_rd;
    logic [1:0] issue_class;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       long_done_valid;
    logic [4:0] long_done_rd;
    logic       flush;
    logic       stall;
    logic       issue_fire;
    logic       long_full;
    logic       busy;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        output issue_we, issue_rd, issue_class, wb_valid, wb_rd,
        output long_done_valid, long_done_rd, flush,
        input  stall, issue_fire, long_full, busy
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        input  issue_we, issue_rd, issue_class, wb_valid, wb_rd,
        input  long_done_valid, long_done_rd, flush,
        output stall, issue_fire, long_full, busy
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Register-write scoreboard: tracks in-flight ALU/LOAD/LONG producers and stalls ID on hazards.
// Optional SB_PERF_CNT_EN adds stall_cycles / long_stall_cycles counters.
module wb_scoreboard #(
    parameter int unsigned MAX_LONG = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    wb_scoreboard_if.slave    sb
`ifdef SB_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       long_stall_cycles
`endif
);

    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_LONG = 2'd2;

    logic [1:0]  inflight  [32];
    logic [1:0]  ready_cnt [32];
    logic [31:0] long_pend;
    logic [1:0]  long_cnt;

    logic        hz_rs1, hz_rs2, waw, lfull;
    logic        is_long, is_load, fire_wr, wb_ok, done_ok, long_inc;
    logic [31:0] issue_hit, wb_hit, long_set, long_clr, inflight_nz;

    assign is_long = (sb.issue_class == CLS_LONG);
    assign is_load = (sb.issue_class == CLS_LOAD);

    assign hz_rs1 = sb.issue_use_rs1 && (sb.issue_rs1 != 5'd0) &&
                    (((inflight[sb.issue_rs1] != 2'd0) && (ready_cnt[sb.issue_rs1] != 2'd0)) ||
                     long_pend[sb.issue_rs1]);
    assign hz_rs2 = sb.issue_use_rs2 && (sb.issue_rs2 != 5'd0) &&
                    (((inflight[sb.issue_rs2] != 2'd0) && (ready_cnt[sb.issue_rs2] != 2'd0)) ||
                     long_pend[sb.issue_rs2]);
    assign waw    = sb.issue_we && (sb.issue_rd != 5'd0) && long_pend[sb.issue_rd];
    assign lfull  = is_long && (long_cnt == 2'(MAX_LONG));

    assign sb.stall      = sb.issue_valid && (hz_rs1 || hz_rs2 || waw || lfull);
    // Gated by rstn so nothing is accepted while the block is held in reset.
    assign sb.issue_fire = rstn && sb.issue_valid && !sb.stall && !sb.flush;
    assign sb.long_full  = (long_cnt == 2'(MAX_LONG));

    assign fire_wr  = sb.issue_fire && sb.issue_we && (sb.issue_rd != 5'd0);
    assign wb_ok    = sb.wb_valid && (sb.wb_rd != 5'd0) && !sb.flush;
    assign done_ok  = sb.long_done_valid && long_pend[sb.long_done_rd];
    assign long_inc = fire_wr && is_long;

    always_comb begin
        issue_hit   = '0;
        wb_hit      = '0;
        long_set    = '0;
        long_clr    = '0;
        inflight_nz = '0;
        for (int r = 1; r < 32; r++) begin
            issue_hit[r]   = fire_wr && !is_long && (sb.issue_rd == 5'(r));
            wb_hit[r]      = wb_ok && (sb.wb_rd == 5'(r));
            long_set[r]    = long_inc && (sb.issue_rd == 5'(r));
            long_clr[r]    = done_ok && (sb.long_done_rd == 5'(r));
            inflight_nz[r] = (inflight[r] != 2'd0);
        end
    end

    assign sb.busy = (|inflight_nz) || (|long_pend);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < 32; r++) begin
                inflight[r]  <= 2'd0;
                ready_cnt[r] <= 2'd0;
            end
            long_pend <= '0;
            long_cnt  <= 2'd0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (sb.flush) begin
                    inflight[r]  <= 2'd0;
                    ready_cnt[r] <= 2'd0;
                end else begin
                    case ({issue_hit[r], wb_hit[r]})
                        2'b10:   if (inflight[r] != 2'd3) inflight[r] <= inflight[r] + 2'd1;
                        2'b01:   if (inflight[r] != 2'd0) inflight[r] <= inflight[r] - 2'd1;
                        default: ;
                    endcase
                    // ready_cnt always reflects the youngest producer of r.
                    if (issue_hit[r])
                        ready_cnt[r] <= is_load ? 2'(LOAD_LAT) : 2'd0;
                    else if (ready_cnt[r] != 2'd0)
                        ready_cnt[r] <= ready_cnt[r] - 2'd1;
                end
                if (long_set[r])
                    long_pend[r] <= 1'b1;
                else if (long_clr[r])
                    long_pend[r] <= 1'b0;
            end
            case ({long_inc, done_ok})
                2'b10:   long_cnt <= long_cnt + 2'd1;
                2'b01:   long_cnt <= long_cnt - 2'd1;
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rstn) begin
            assert (sb.flush || !(fire_wr && !is_long && inflight[sb.issue_rd] == 2'd3 &&
                                  !(wb_ok && sb.wb_rd == sb.issue_rd)));
            assert (!(wb_ok && inflight[sb.wb_rd] == 2'd0 &&
                      !(fire_wr && !is_long && sb.issue_rd == sb.wb_rd)));
            assert (!(sb.long_done_valid && !long_pend[sb.long_done_rd]));
        end
    end

`ifdef SB_PERF_CNT_EN
    logic short1, short2, long_only;

    // A stall is "long" when no ordinary (non-long) read hazard contributes to it.
    assign short1 = sb.issue_use_rs1 && (sb.issue_rs1 != 5'd0) && !long_pend[sb.issue_rs1] &&
                    (inflight[sb.issue_rs1] != 2'd0) && (ready_cnt[sb.issue_rs1] != 2'd0);
    assign short2 = sb.issue_use_rs2 && (sb.issue_rs2 != 5'd0) && !long_pend[sb.issue_rs2] &&
                    (inflight[sb.issue_rs2] != 2'd0) && (ready_cnt[sb.issue_rs2] != 2'd0);
    assign long_only = sb.stall && !short1 && !short2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles      <= '0;
            long_stall_cycles <= '0;
        end else begin
            if (sb.stall) stall_cycles <= stall_cycles + 32'd1;
            if (long_only) long_stall_cycles <= long_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
